// File: rtl/array_results_drain.sv
// array_results_drain: diagonal-wavefront capture of PE results into ping-pong banks,
// drained as masked, coordinate-tagged bus beats under valid/ready.
module array_results_drain #(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int BUS_WIDTH    = 256
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic                                                   cfg_start,
  input  logic [15:0]                                            m,
  input  logic [15:0]                                            p,
  input  logic                                                   tile_done,
  output logic                                                   tile_ready,
  input  logic [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] array_results,
  output logic [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0]               array_reset_n,
  output logic [BUS_WIDTH-1:0]                                   data_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0]                        mask_o,
  output logic [15:0]                                            row_o,
  output logic [15:0]                                            col_o,
  output logic                                                   valid_o,
  input  logic                                                   ready_i,
  output logic                                                   last_o,
  output logic                                                   done,
  output logic                                                   err
);
  localparam int H  = ARRAY_HEIGHT;
  localparam int W  = ARRAY_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int E  = BUS_WIDTH / DATA_WIDTH;
  localparam int NC = W / E;
  localparam int DB = $clog2(H + W);
  localparam int RB = H > 1 ? $clog2(H) : 1;
  localparam int CB = NC > 1 ? $clog2(NC) : 1;
  localparam int WB = W > 1 ? $clog2(W) : 1;

  typedef enum logic {C_IDLE, C_CAP} cap_t;
  cap_t cap_state, cap_next;

  logic [DB-1:0] d;
  logic [1:0]    full;
  logic          wr, rd;
  logic [15:0]   m_q, p_q, tile_row, tile_col;
  logic [15:0]   bank_row [2];
  logic [15:0]   bank_col [2];
  logic [1:0]    bank_last;
  logic [DW-1:0] bank [2][H][W];
  logic [RB-1:0] r;
  logic [CB-1:0] c;
  logic [16:0]   row17, col17;
  logic          cap_end, accept, hs, chunk_end, row_last, beat_end, row_end, col_end;

  assign cap_end   = cap_state == C_CAP && d == DB'(H + W - 1);
  assign accept    = tile_done && tile_ready;
  assign row_end   = 17'(tile_row) + 17'(H) >= {1'b0, m_q};
  assign col_end   = 17'(tile_col) + 17'(W) >= {1'b0, p_q};
  assign row17     = 17'(bank_row[rd]) + 17'(r);
  assign col17     = 17'(bank_col[rd]) + 17'(int'(c) * E);
  assign chunk_end = c == CB'(NC - 1) || col17 + 17'(E) >= {1'b0, p_q};
  assign row_last  = r == RB'(H - 1) || row17 + 17'd1 >= {1'b0, m_q};
  assign beat_end  = chunk_end && row_last;
  assign valid_o   = full[rd];
  assign hs        = valid_o && ready_i;
  assign last_o    = valid_o && bank_last[rd] && beat_end;
  assign row_o     = valid_o ? row17[15:0] : '0;
  assign col_o     = valid_o ? col17[15:0] : '0;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cap_state <= C_IDLE;
    else cap_state <= cfg_start ? C_IDLE : cap_next;

  always_comb
    cap_next = cap_state == C_IDLE ? (accept ? C_CAP : C_IDLE) : (cap_end ? C_IDLE : C_CAP);

  always_comb begin
    tile_ready    = cap_state == C_IDLE && !full[wr];
    array_reset_n = '1;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        array_reset_n[i][j] = !(cap_state == C_CAP && d == DB'(i + j + 1));
  end

  // each PE is copied on the same edge at which its clear takes effect
  always_ff @(posedge clk)
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        if (cap_state == C_CAP && d == DB'(i + j + 1)) bank[wr][i][j] <= array_results[i][j];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) d <= DB'(1);
    else d <= (cfg_start || cap_state == C_IDLE) ? DB'(1) : d + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= '0; wr <= 1'b0; rd <= 1'b0; m_q <= '0; p_q <= '0;
      tile_row <= '0; tile_col <= '0; bank_last <= '0;
      bank_row[0] <= '0; bank_row[1] <= '0; bank_col[0] <= '0; bank_col[1] <= '0;
      r <= '0; c <= '0; err <= 1'b0; done <= 1'b0;
    end else if (cfg_start) begin
      full <= '0; wr <= 1'b0; rd <= 1'b0; m_q <= m; p_q <= p;
      tile_row <= '0; tile_col <= '0; bank_last <= '0;
      r <= '0; c <= '0; err <= 1'b0;
      done <= m == '0 || p == '0;
    end else begin
      done <= hs && last_o;
      err  <= err || (tile_done && !tile_ready);
      if (accept) begin
        bank_row[wr]  <= tile_row;
        bank_col[wr]  <= tile_col;
        bank_last[wr] <= row_end && col_end;
        tile_col      <= col_end ? '0 : tile_col + 16'(W);
        if (col_end) tile_row <= tile_row + 16'(H);
      end
      if (cap_end) begin
        full[wr] <= 1'b1;
        wr       <= ~wr;
      end
      if (hs) begin
        if (beat_end) begin
          r <= '0; c <= '0; full[rd] <= 1'b0; rd <= ~rd;
        end else if (chunk_end) begin
          c <= '0; r <= r + 1'b1;
        end else c <= c + 1'b1;
      end
    end
  end

  always_comb begin
    mask_o = '0;
    data_o = '0;
    for (int k = 0; k < E; k++) begin
      mask_o[k] = valid_o && row17 < {1'b0, m_q} && col17 + 17'(k) < {1'b0, p_q};
      data_o[k*DW +: DW] = mask_o[k] ? bank[rd][r][WB'(int'(c) * E + k)] : '0;
    end
  end
endmodule

// File: tb/tb_array_results_drain.sv
// tb_array_results_drain: directed scenarios with a beat scoreboard fed at tile issue
// and checked by a bus monitor, including stall-stability checks.
module tb_array_results_drain;
  localparam int H = 4, W = 32, DW = 16, BW = 256, E = BW / DW, NC = W / E;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [E-1:0]  mask;
    logic [15:0]   row;
    logic [15:0]   col;
    logic          last;
  } beat_t;

  logic clk = 0, reset_n = 0, cfg_start = 0, tile_done = 0, ready_i = 1, load = 0, toggle_en = 0;
  logic [15:0] m = 0, p = 0;
  logic [H-1:0][W-1:0][DW-1:0] array_results;
  logic [H-1:0][W-1:0] array_reset_n;
  logic [BW-1:0] data_o;
  logic [E-1:0] mask_o;
  logic [15:0] row_o, col_o;
  logic valid_o, last_o, done, err, tile_ready;

  int n_assert = 0, n_fail = 0, cyc = 0, beats = 0, seed = 0;
  int m_cur = 0, p_cur = 0, br = 0, bc = 0, t0 = 0;
  beat_t sb[$];
  beat_t held;
  logic stall = 0;

  array_results_drain dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .m(m), .p(p),
    .tile_done(tile_done), .tile_ready(tile_ready), .array_results(array_results),
    .array_reset_n(array_reset_n), .data_o(data_o), .mask_o(mask_o), .row_o(row_o),
    .col_o(col_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int s, input int i, input int j);
    return 16'(s * 1024 + i * W + j + 1);
  endfunction

  // PE accumulators: loadable ramp, cleared by the DUT's per-PE reset
  always @(posedge clk)
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        if (!array_reset_n[i][j]) array_results[i][j] <= '0;
        else if (load) array_results[i][j] <= pat(seed, i, j);

  always begin
    @(posedge clk);
    #1 ready_i = toggle_en ? ~ready_i : 1'b1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) stall = 1'b0;
    else begin
      if (stall) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_beat", {data_o, mask_o, row_o, col_o, last_o}, held);
      end
      if (valid_o && ready_i) begin
        beats++;
        chk("beat_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          beat_t b;
          b = sb.pop_front();
          chk("beat_data", data_o, b.data);
          chk("beat_mask", mask_o, b.mask);
          chk("beat_row", row_o, b.row);
          chk("beat_col", col_o, b.col);
          chk("beat_last", last_o, b.last);
        end
      end
      stall = valid_o && !ready_i;
      held  = {data_o, mask_o, row_o, col_o, last_o};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int mm, input int pp);
    m = 16'(mm); p = 16'(pp);
    cfg_start = 1; step(); cfg_start = 0;
    m_cur = mm; p_cur = pp; br = 0; bc = 0;
  endtask

  task automatic push_tile(input int s);
    beat_t b;
    for (int r = 0; r < H; r++)
      if (br + r < m_cur)
        for (int c = 0; c < NC; c++)
          if (bc + c * E < p_cur) begin
            b = '0;
            b.row = 16'(br + r);
            b.col = 16'(bc + c * E);
            for (int k = 0; k < E; k++)
              if (bc + c * E + k < p_cur) begin
                b.mask[k] = 1'b1;
                b.data[k*DW +: DW] = pat(s, r, c * E + k);
              end
            sb.push_back(b);
          end
    if (br + H >= m_cur && bc + W >= p_cur) begin
      b = sb.pop_back(); b.last = 1'b1; sb.push_back(b);
    end
  endtask

  task automatic issue_tile(input int s, output int t);
    int n = 0;
    while (!tile_ready && n < 500) begin step(); n++; end
    chk("tile_ready_wait", tile_ready, 1);
    seed = s; load = 1; step(); load = 0;
    tile_done = 1; t = cyc; push_tile(s);
    step(); tile_done = 0;
    if (bc + W >= p_cur) begin bc = 0; br += H; end else bc += W;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid_o && n < 500) begin step(); n++; end
    chk("valid_wait", valid_o, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin step(); n++; end
    chk("done_wait", done, 1);
  endtask

  task automatic scen1();
    cfg(4, 32);
    beats = 0;
    issue_tile(1, t0);
    for (int k = 1; k <= 44; k++) begin
      if (k == 1) chk("pe00_clr_t1", array_reset_n[0][0], 0);
      if (k == 1) chk("pe01_idle_t1", array_reset_n[0][1], 1);
      if (k == 2) chk("pe00_clr_t2", array_reset_n[0][0], 1);
      if (k == 4) chk("pe12_clr_t4", array_reset_n[1][2], 0);
      if (k == 34) chk("pe_last_t34", array_reset_n[H-1][W-1], 1);
      if (k == 35) chk("pe_last_t35", array_reset_n[H-1][W-1], 0);
      if (k == 35) chk("valid_t35", valid_o, 0);
      if (k == 36) chk("valid_t36", valid_o, 1);
      if (k == 43) chk("done_t43", done, 0);
      if (k == 44) chk("done_t44", done, 1);
      if (k < 44) step();
    end
    chk("s1_beats", beats, 8);
    chk("s1_sb_empty", sb.size(), 0);
    chk("s1_pe_cleared", array_results, 0);
    step();
    chk("s1_done_pulse", done, 0);
  endtask

  initial begin
    int any_valid;
    step(); step();
    chk("rst_tile_ready", tile_ready, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arr_n", array_reset_n, {H*W{1'b1}});
    chk("rst_bus", {data_o, mask_o, row_o, col_o, last_o}, 0);
    reset_n = 1;
    step();

    scen1();

    cfg(6, 40);
    beats = 0;
    for (int s = 10; s < 14; s++) issue_tile(s, t0);
    wait_done();
    step();
    chk("s3_beats", beats, 18);
    chk("s3_sb_empty", sb.size(), 0);

    cfg(4, 64);
    beats = 0;
    toggle_en = 1;
    issue_tile(20, t0);
    wait_valid();
    issue_tile(21, t0);
    repeat (5) step();
    chk("s4_busy_ready", tile_ready, 0);
    tile_done = 1; step(); tile_done = 0;
    chk("s4_err", err, 1);
    wait_done();
    step();
    toggle_en = 0;
    chk("s4_beats", beats, 16);
    chk("s4_sb_empty", sb.size(), 0);
    chk("s4_err_sticky", err, 1);

    cfg(4, 32);
    chk("s5_err_cleared", err, 0);
    issue_tile(30, t0);
    wait_valid();
    step(); step();
    reset_n = 0;
    #1;
    chk("s5_valid_async", valid_o, 0);
    sb.delete();
    step();
    reset_n = 1;
    step();
    chk("s5_tile_ready", tile_ready, 1);
    chk("s5_arr_n", array_reset_n, {H*W{1'b1}});
    scen1();

    cfg(0, 32);
    chk("s6_done", done, 1);
    any_valid = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) any_valid = 1;
    end
    chk("s6_no_valid", any_valid, 0);
    chk("s6_done_clear", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
